fwd_engine: RTL

- Forwarding decision stage that consumes the forwarding lookup table's read port (fwd_rden/fwd_addr/fwd_data).
- Accepts one lookup request per packet from the ingress parser: 8-bit destination key plus one-hot ingress channel.
- Reads the table, splits the entry into a channel mask and a 12-bit label, and removes the ingress channel from the mask.
- Hands the decision to the egress scheduler over a valid/ready interface and keeps hit/miss statistics.

---
 rtl/fwd_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fwd_engine.sv
// -----------------------------------------------------------------------------
// fwd_engine
//   Forwarding decision stage. Takes one lookup request (destination key plus
//   one-hot ingress channel) from the ingress parser, reads the forwarding
//   table, strips the ingress channel from the entry's channel mask and hands
//   the decision to the egress scheduler over valid/ready. Keeps saturating
//   hit/miss counters.
//
// Optional feature (compile-time macro FWD_FLOOD_EN):
//   When defined, a miss (no egress channel left) floods to every channel
//   except the ingress one, with label 0. When undefined, a miss carries an
//   all-zero mask and the downstream drops the packet.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  lookup request handshake
//   req_dst [7:0]        destination key (table address)
//   req_src [CH-1:0]     one-hot ingress channel
//   fwd_rden, fwd_addr   table read strobe/address
//   fwd_data             table entry {mask[CH-1:0], label[LBL_W-1:0]}, valid
//                        the cycle after fwd_rden
//   rsp_valid/rsp_ready  decision handshake
//   rsp_mask/label/miss  decision payload
//   cnt_clr              synchronous clear of both counters
//   hit_cnt, miss_cnt    saturating statistics counters
// -----------------------------------------------------------------------------
`ifndef CHANNEL_NUM
`define CHANNEL_NUM 4
`endif

module fwd_engine #(
    parameter int CH    = `CHANNEL_NUM,
    parameter int LBL_W = 12,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_dst,
    input  logic [CH-1:0]         req_src,
    output logic                  fwd_rden,
    output logic [7:0]            fwd_addr,
    input  logic [LBL_W+CH-1:0]   fwd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [CH-1:0]         rsp_mask,
    output logic [LBL_W-1:0]      rsp_label,
    output logic                  rsp_miss,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

    state_t             state_q;
    logic [7:0]         dst_q;
    logic [CH-1:0]      src_q;
    logic               req_ready_q;
    logic               fwd_rden_q;
    logic               rsp_valid_q;
    logic [CH-1:0]      rsp_mask_q;
    logic [LBL_W-1:0]   rsp_label_q;
    logic               rsp_miss_q;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [CH-1:0]      m_d;
    logic [CH-1:0]      rsp_mask_d;
    logic [LBL_W-1:0]   rsp_label_d;
    logic               rsp_miss_d;
    logic               hs;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Decision computed from the table entry; only registered in CAP.
    always_comb begin
        m_d         = fwd_data[LBL_W+CH-1:LBL_W] & ~src_q;
        rsp_mask_d  = m_d;
        rsp_label_d = fwd_data[LBL_W-1:0];
        rsp_miss_d  = (m_d == '0);
`ifdef FWD_FLOOD_EN
        if (rsp_miss_d) begin
            rsp_mask_d  = ~src_q;
            rsp_label_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dst_q       <= '0;
            src_q       <= '0;
            req_ready_q <= 1'b1;
            fwd_rden_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_mask_q  <= '0;
            rsp_label_q <= '0;
            rsp_miss_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        dst_q       <= req_dst;
                        src_q       <= req_src;
                        req_ready_q <= 1'b0;
                        fwd_rden_q  <= 1'b1;   // strobe lands in RD
                        state_q     <= RD;
                    end
                end
                RD: begin
                    fwd_rden_q <= 1'b0;
                    state_q    <= CAP;
                end
                CAP: begin
                    rsp_mask_q  <= rsp_mask_d;
                    rsp_label_q <= rsp_label_d;
                    rsp_miss_q  <= rsp_miss_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hs = rsp_valid_q & rsp_ready;

    // Clear has priority over a coincident handshake.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (hs) begin
            if (rsp_miss_q) miss_cnt_d = sat_inc(miss_cnt_q);
            else            hit_cnt_d  = sat_inc(hit_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // fwd_addr is the latched key, so it holds between reads.
    assign req_ready = req_ready_q;
    assign fwd_rden  = fwd_rden_q;
    assign fwd_addr  = dst_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_mask  = rsp_mask_q;
    assign rsp_label = rsp_label_q;
    assign rsp_miss  = rsp_miss_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
